// File: rtl/cu_stepper.sv
// Control-unit step sequencer: four-phase steps, one-hot step vector, clk_e/clk_s strobes,
// free-run / halt-at-boundary / single-instruction / early-termination control.
module cu_stepper #(
    parameter  int NUM_STEPS = 6,
    localparam int SW        = $clog2(NUM_STEPS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic                 single,
    input  logic                 end_early,
    output logic [NUM_STEPS-1:0] step,
    output logic [SW-1:0]        step_idx,
    output logic [1:0]           phase,
    output logic                 clk_e,
    output logic                 clk_s,
    output logic                 busy,
    output logic                 instr_start,
    output logic                 instr_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] idx_q, idx_d;
    logic [1:0]    phase_q, phase_d;
    logic          single_q;
    logic          single_edge;
    logic          last_step;
    logic          term;

    // single_q resets high so a level held through reset release is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            phase_q  <= 2'd0;
            single_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            single_q <= single;
        end
    end

    assign single_edge = single & ~single_q;
    assign last_step   = (idx_q == SW'(NUM_STEPS - 1));
    assign term        = (state_q == RUN) && (phase_q == 2'd3) && (last_step || end_early);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (run || single_edge) begin
                    state_d = RUN;
                    idx_d   = '0;
                    phase_d = 2'd0;
                end
            end
            RUN: begin
                if (phase_q != 2'd3) begin
                    phase_d = phase_q + 2'd1;
                end else if (term) begin
                    phase_d = 2'd0;
                    idx_d   = '0;
                    if (!run) state_d = IDLE;
                end else begin
                    phase_d = 2'd0;
                    idx_d   = idx_q + SW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                phase_d = 2'd0;
            end
        endcase
    end

    assign busy        = (state_q == RUN);
    assign step        = busy ? ({{(NUM_STEPS-1){1'b0}}, 1'b1} << idx_q) : '0;
    assign step_idx    = idx_q;
    assign phase       = phase_q;
    assign clk_e       = busy && (phase_q != 2'd3);
    assign clk_s       = busy && (phase_q == 2'd1);
    assign instr_start = busy && (idx_q == '0) && (phase_q == 2'd0);
    // end_early reaches instr_done in the same phase-3 cycle that terminates the step.
    assign instr_done  = term;

endmodule
